// File: rtl/wired_iq_age.sv
// Age-ordered issue queue: accepts DISP_CNT/cycle, snoops CDB_CNT buses, issues oldest-ready first on ISSUE_CNT ports.
// Latency dispatch->iss_valid_o 2 cycles; stalled port holds its outputs; disp_ready_o depends on registered count only.
module wired_iq_age #(
    parameter int IQ_SIZE   = 8,
    parameter int DISP_CNT  = 2,
    parameter int ISSUE_CNT = 2,
    parameter int CDB_CNT   = 2,
    parameter int SRC_CNT   = 2,
    parameter int DATA_W    = 32,
    parameter int RID_W     = 6,
    parameter int PAYLOAD_W = 64
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            flush_i,
    input  logic [DISP_CNT-1:0]                             disp_valid_i,
    input  logic [DISP_CNT-1:0][RID_W-1:0]                  disp_rid_i,
    input  logic [DISP_CNT-1:0][SRC_CNT-1:0]                disp_src_rdy_i,
    input  logic [DISP_CNT-1:0][SRC_CNT-1:0][RID_W-1:0]     disp_src_rid_i,
    input  logic [DISP_CNT-1:0][SRC_CNT-1:0][DATA_W-1:0]    disp_src_data_i,
    input  logic [DISP_CNT-1:0][PAYLOAD_W-1:0]              disp_payload_i,
    output logic                                            disp_ready_o,
    input  logic [CDB_CNT-1:0]                              cdb_valid_i,
    input  logic [CDB_CNT-1:0][RID_W-1:0]                   cdb_rid_i,
    input  logic [CDB_CNT-1:0][DATA_W-1:0]                  cdb_data_i,
    output logic [ISSUE_CNT-1:0]                            iss_valid_o,
    output logic [ISSUE_CNT-1:0][RID_W-1:0]                 iss_rid_o,
    output logic [ISSUE_CNT-1:0][SRC_CNT-1:0][DATA_W-1:0]   iss_data_o,
    output logic [ISSUE_CNT-1:0][PAYLOAD_W-1:0]             iss_payload_o,
    input  logic [ISSUE_CNT-1:0]                            iss_ready_i,
    output logic [$clog2(IQ_SIZE+1)-1:0]                    count_o
);

    localparam int CNT_W = $clog2(IQ_SIZE + 1);
    localparam int IDX_W = (IQ_SIZE > 1) ? $clog2(IQ_SIZE) : 1;

    typedef struct packed {
        logic [RID_W-1:0]                   rid;
        logic [SRC_CNT-1:0]                 src_rdy;
        logic [SRC_CNT-1:0][RID_W-1:0]      src_rid;
        logic [SRC_CNT-1:0][DATA_W-1:0]     src_data;
        logic [PAYLOAD_W-1:0]               payload;
    } entry_t;

    logic [IQ_SIZE-1:0]                 valid_q, valid_n;
    logic [IQ_SIZE-1:0][IQ_SIZE-1:0]    age_q, age_n;
    entry_t [IQ_SIZE-1:0]               ent_q, ent_n;
    logic [CNT_W-1:0]                   count_q, count_n;
    logic [CNT_W-1:0]                   acc_cnt, iss_cnt;

    logic [IQ_SIZE-1:0]                 ent_rdy;
    logic [ISSUE_CNT-1:0]               ld;
    logic [ISSUE_CNT-1:0]               pick_vld;
    logic [ISSUE_CNT-1:0][IDX_W-1:0]    pick_idx;
    logic [IQ_SIZE-1:0]                 freed;
    logic [IQ_SIZE-1:0]                 sel_cand;
    logic                               sel_older;

    logic [IQ_SIZE-1:0]                 alloc_free;
    logic [DISP_CNT-1:0]                alloc_vld;
    logic [DISP_CNT-1:0][IDX_W-1:0]     alloc_idx;
    entry_t [DISP_CNT-1:0]              disp_ent;

    assign count_o      = count_q;
    assign disp_ready_o = (CNT_W'(IQ_SIZE) - count_q) >= CNT_W'(DISP_CNT);
    assign ld           = ~iss_valid_o | iss_ready_i;

    always_comb begin
        ent_rdy = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            ent_rdy[i] = valid_q[i] & (&ent_q[i].src_rdy);
        end
    end

    // Each loading port picks the ready entry that no other remaining candidate is older than.
    always_comb begin
        freed     = '0;
        pick_vld  = '0;
        pick_idx  = '0;
        sel_cand  = '0;
        sel_older = 1'b0;
        for (int p = 0; p < ISSUE_CNT; p++) begin
            sel_cand = ent_rdy & ~freed;
            if (ld[p]) begin
                for (int i = 0; i < IQ_SIZE; i++) begin
                    sel_older = 1'b0;
                    for (int j = 0; j < IQ_SIZE; j++) begin
                        if (sel_cand[j] && age_q[j][i]) sel_older = 1'b1;
                    end
                    if (sel_cand[i] && !sel_older) begin
                        pick_vld[p] = 1'b1;
                        pick_idx[p] = IDX_W'(i);
                    end
                end
                if (pick_vld[p]) freed[pick_idx[p]] = 1'b1;
            end
        end
    end

    // Only entries free at the start of the cycle are allocated; same-cycle issues are not reused.
    always_comb begin
        alloc_free = ~valid_q;
        alloc_vld  = '0;
        alloc_idx  = '0;
        for (int k = 0; k < DISP_CNT; k++) begin
            if (disp_valid_i[k] && disp_ready_o) begin
                for (int i = IQ_SIZE - 1; i >= 0; i--) begin
                    if (alloc_free[i]) begin
                        alloc_vld[k] = 1'b1;
                        alloc_idx[k] = IDX_W'(i);
                    end
                end
                if (alloc_vld[k]) alloc_free[alloc_idx[k]] = 1'b0;
            end
        end
    end

    // Dispatch bypass: descending CDB scan so the lowest matching bus wins.
    always_comb begin
        disp_ent = '0;
        for (int k = 0; k < DISP_CNT; k++) begin
            disp_ent[k].rid      = disp_rid_i[k];
            disp_ent[k].src_rdy  = disp_src_rdy_i[k];
            disp_ent[k].src_rid  = disp_src_rid_i[k];
            disp_ent[k].src_data = disp_src_data_i[k];
            disp_ent[k].payload  = disp_payload_i[k];
            for (int s = 0; s < SRC_CNT; s++) begin
                if (!disp_src_rdy_i[k][s]) begin
                    for (int c = CDB_CNT - 1; c >= 0; c--) begin
                        if (cdb_valid_i[c] && (cdb_rid_i[c] == disp_src_rid_i[k][s])) begin
                            disp_ent[k].src_rdy[s]  = 1'b1;
                            disp_ent[k].src_data[s] = cdb_data_i[c];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        acc_cnt = '0;
        iss_cnt = '0;
        for (int k = 0; k < DISP_CNT; k++) begin
            if (alloc_vld[k]) acc_cnt = acc_cnt + CNT_W'(1);
        end
        for (int p = 0; p < ISSUE_CNT; p++) begin
            if (pick_vld[p]) iss_cnt = iss_cnt + CNT_W'(1);
        end
        count_n = count_q + acc_cnt - iss_cnt;
    end

    always_comb begin
        ent_n   = ent_q;
        valid_n = valid_q & ~freed;
        age_n   = age_q;
        for (int i = 0; i < IQ_SIZE; i++) begin
            for (int j = 0; j < IQ_SIZE; j++) begin
                if (freed[i] || freed[j]) age_n[i][j] = 1'b0;
            end
        end
        for (int i = 0; i < IQ_SIZE; i++) begin
            for (int s = 0; s < SRC_CNT; s++) begin
                if (!ent_q[i].src_rdy[s]) begin
                    for (int c = CDB_CNT - 1; c >= 0; c--) begin
                        if (cdb_valid_i[c] && (cdb_rid_i[c] == ent_q[i].src_rid[s])) begin
                            ent_n[i].src_rdy[s]  = 1'b1;
                            ent_n[i].src_data[s] = cdb_data_i[c];
                        end
                    end
                end
            end
        end
        // New entries are younger than every surviving entry and than lower dispatch slots.
        for (int k = 0; k < DISP_CNT; k++) begin
            if (alloc_vld[k]) begin
                valid_n[alloc_idx[k]] = 1'b1;
                ent_n[alloc_idx[k]]   = disp_ent[k];
                for (int j = 0; j < IQ_SIZE; j++) begin
                    age_n[j][alloc_idx[k]] = valid_q[j] & ~freed[j];
                end
                for (int m = 0; m < k; m++) begin
                    if (alloc_vld[m]) age_n[alloc_idx[m]][alloc_idx[k]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            age_q       <= '0;
            count_q     <= '0;
            iss_valid_o <= '0;
        end else if (flush_i) begin
            valid_q     <= '0;
            age_q       <= '0;
            count_q     <= '0;
            iss_valid_o <= '0;
        end else begin
            valid_q <= valid_n;
            age_q   <= age_n;
            count_q <= count_n;
            for (int p = 0; p < ISSUE_CNT; p++) begin
                if (ld[p]) iss_valid_o[p] <= pick_vld[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_n;
        for (int p = 0; p < ISSUE_CNT; p++) begin
            if (ld[p] && pick_vld[p]) begin
                iss_rid_o[p]     <= ent_q[pick_idx[p]].rid;
                iss_data_o[p]    <= ent_q[pick_idx[p]].src_data;
                iss_payload_o[p] <= ent_q[pick_idx[p]].payload;
            end
        end
    end

endmodule

// File: tb/tb_wired_iq_age.sv
// Bench for wired_iq_age: vector table, directed corner sequences and random traffic vs. a queue model.
module tb_wired_iq_age;

    localparam int IQ = 8, DC = 2, IC = 2, CC = 2, SC = 2, DW = 32, RW = 6, PW = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic [DC-1:0]                  disp_valid;
    logic [DC-1:0][RW-1:0]          disp_rid;
    logic [DC-1:0][SC-1:0]          disp_src_rdy;
    logic [DC-1:0][SC-1:0][RW-1:0]  disp_src_rid;
    logic [DC-1:0][SC-1:0][DW-1:0]  disp_src_data;
    logic [DC-1:0][PW-1:0]          disp_payload;
    logic                           disp_ready;
    logic [CC-1:0]                  cdb_valid;
    logic [CC-1:0][RW-1:0]          cdb_rid;
    logic [CC-1:0][DW-1:0]          cdb_data;
    logic [IC-1:0]                  iss_valid;
    logic [IC-1:0][RW-1:0]          iss_rid;
    logic [IC-1:0][SC-1:0][DW-1:0]  iss_data;
    logic [IC-1:0][PW-1:0]          iss_payload;
    logic [IC-1:0]                  iss_ready;
    logic [3:0]                     count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wired_iq_age #(
        .IQ_SIZE(IQ), .DISP_CNT(DC), .ISSUE_CNT(IC), .CDB_CNT(CC),
        .SRC_CNT(SC), .DATA_W(DW), .RID_W(RW), .PAYLOAD_W(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .disp_valid_i(disp_valid), .disp_rid_i(disp_rid), .disp_src_rdy_i(disp_src_rdy),
        .disp_src_rid_i(disp_src_rid), .disp_src_data_i(disp_src_data), .disp_payload_i(disp_payload),
        .disp_ready_o(disp_ready),
        .cdb_valid_i(cdb_valid), .cdb_rid_i(cdb_rid), .cdb_data_i(cdb_data),
        .iss_valid_o(iss_valid), .iss_rid_o(iss_rid), .iss_data_o(iss_data),
        .iss_payload_o(iss_payload), .iss_ready_i(iss_ready), .count_o(count)
    );

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain list of entries in age order (oldest first) plus the port registers.
    typedef struct {
        logic [RW-1:0]          rid;
        logic [SC-1:0]          rdy;
        logic [SC-1:0][RW-1:0]  srid;
        logic [SC-1:0][DW-1:0]  dat;
        logic [PW-1:0]          pay;
    } ment_t;

    ment_t      mq[$];
    ment_t      mport[IC];
    logic [IC-1:0] mvld;

    function automatic ment_t wake(input ment_t e);
        ment_t r;
        bit hit;
        r = e;
        for (int s = 0; s < SC; s++) begin
            hit = 1'b0;
            for (int c = 0; c < CC; c++) begin
                if (!r.rdy[s] && !hit && cdb_valid[c] && cdb_rid[c] == r.srid[s]) begin
                    r.rdy[s] = 1'b1;
                    r.dat[s] = cdb_data[c];
                    hit = 1'b1;
                end
            end
        end
        return r;
    endfunction

    task automatic model_step();
        ment_t nq[$];
        ment_t e;
        bit    tk[IQ];
        bit    acc;
        int    f;
        if (!rst_n || flush) begin
            mq.delete();
            mvld = '0;
            return;
        end
        acc = (IQ - mq.size()) >= DC;
        for (int i = 0; i < IQ; i++) tk[i] = 1'b0;
        for (int p = 0; p < IC; p++) begin
            if (!mvld[p] || iss_ready[p]) begin
                f = -1;
                for (int i = 0; i < mq.size(); i++) begin
                    if (f < 0 && !tk[i] && mq[i].rdy == '1) f = i;
                end
                if (f >= 0) begin
                    mport[p] = mq[f];
                    tk[f]    = 1'b1;
                    mvld[p]  = 1'b1;
                end else begin
                    mvld[p] = 1'b0;
                end
            end
        end
        for (int i = 0; i < mq.size(); i++) begin
            if (!tk[i]) nq.push_back(wake(mq[i]));
        end
        if (acc) begin
            for (int k = 0; k < DC; k++) begin
                if (disp_valid[k]) begin
                    e.rid  = disp_rid[k];
                    e.rdy  = disp_src_rdy[k];
                    e.srid = disp_src_rid[k];
                    e.dat  = disp_src_data[k];
                    e.pay  = disp_payload[k];
                    nq.push_back(wake(e));
                end
            end
        end
        mq = nq;
    endtask

    task automatic compare_model();
        chk("m_count", count, mq.size());
        chk("m_disp_ready", disp_ready, (IQ - mq.size()) >= DC);
        for (int p = 0; p < IC; p++) begin
            chk("m_iss_valid", iss_valid[p], mvld[p]);
            if (mvld[p])
                chk("m_iss_port", {iss_rid[p], iss_data[p], iss_payload[p]},
                                  {mport[p].rid, mport[p].dat, mport[p].pay});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle();
        disp_valid = '0;
        cdb_valid  = '0;
        flush      = 1'b0;
    endtask

    task automatic set_slot(input int k, input logic [RW-1:0] rid, input logic [SC-1:0] rdy,
                            input logic [RW-1:0] w);
        disp_valid[k]   = 1'b1;
        disp_rid[k]     = rid;
        disp_src_rdy[k] = rdy;
        for (int s = 0; s < SC; s++) begin
            disp_src_rid[k][s]  = w;
            disp_src_data[k][s] = $urandom;
        end
        disp_payload[k] = {$urandom, $urandom};
    endtask

    task automatic set_cdb(input int c, input logic [RW-1:0] rid, input logic [DW-1:0] d);
        cdb_valid[c] = 1'b1;
        cdb_rid[c]   = rid;
        cdb_data[c]  = d;
    endtask

    typedef struct {
        logic [1:0] dv;
        bit         cdb;
        logic [1:0] ir;
        int         cnt;
        logic       dr;
        logic [1:0] iv;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{2'b11, 1'b0, 2'b11, 2, 1'b1, 2'b00};
        tbl[1]  = '{2'b01, 1'b0, 2'b11, 3, 1'b1, 2'b00};
        tbl[2]  = '{2'b10, 1'b0, 2'b11, 4, 1'b1, 2'b00};
        tbl[3]  = '{2'b11, 1'b0, 2'b11, 6, 1'b1, 2'b00};
        tbl[4]  = '{2'b01, 1'b0, 2'b11, 7, 1'b0, 2'b00};
        tbl[5]  = '{2'b11, 1'b0, 2'b11, 7, 1'b0, 2'b00};
        tbl[6]  = '{2'b00, 1'b1, 2'b00, 7, 1'b0, 2'b00};
        tbl[7]  = '{2'b00, 1'b0, 2'b00, 5, 1'b1, 2'b11};
        tbl[8]  = '{2'b00, 1'b0, 2'b00, 5, 1'b1, 2'b11};
        tbl[9]  = '{2'b11, 1'b0, 2'b01, 6, 1'b1, 2'b11};
        tbl[10] = '{2'b00, 1'b0, 2'b11, 4, 1'b1, 2'b11};
        tbl[11] = '{2'b00, 1'b0, 2'b11, 2, 1'b1, 2'b11};
        tbl[12] = '{2'b00, 1'b0, 2'b11, 2, 1'b1, 2'b00};
        tbl[13] = '{2'b00, 1'b1, 2'b11, 2, 1'b1, 2'b00};
        tbl[14] = '{2'b00, 1'b0, 2'b11, 0, 1'b1, 2'b11};
        tbl[15] = '{2'b00, 1'b0, 2'b11, 0, 1'b1, 2'b00};

        rst_n = 1'b0;
        idle();
        disp_rid = '0; disp_src_rdy = '0; disp_src_rid = '0; disp_src_data = '0; disp_payload = '0;
        cdb_rid = '0; cdb_data = '0;
        iss_ready = 2'b11;
        mq.delete();
        mvld = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("reset_iss_valid", iss_valid, 2'b00);
        chk("reset_count", count, 0);
        chk("reset_disp_ready", disp_ready, 1'b1);

        // Vector table: entries wait on rid 60 until a row fires the CDB.
        for (int r = 0; r < 16; r++) begin
            idle();
            iss_ready = tbl[r].ir;
            for (int k = 0; k < DC; k++) begin
                if (tbl[r].dv[k]) set_slot(k, 6'(r * 2 + k + 1), 2'b10, 6'd60);
            end
            if (tbl[r].cdb) set_cdb(0, 6'd60, $urandom);
            tick();
            chk("tbl_count", count, tbl[r].cnt);
            chk("tbl_disp_ready", disp_ready, tbl[r].dr);
            chk("tbl_iss_valid", iss_valid, tbl[r].iv);
        end
        idle();
        iss_ready = 2'b11;

        // Out-of-order issue and CDB wakeup.
        set_slot(0, 6'd3, 2'b10, 6'd9);
        set_slot(1, 6'd4, 2'b11, 6'd0);
        tick(); idle();
        tick();
        chk("ooo_p0_valid", iss_valid[0], 1'b1);
        chk("ooo_p0_rid4", iss_rid[0], 6'd4);
        chk("ooo_p1_valid", iss_valid[1], 1'b0);
        tick();
        set_cdb(0, 6'd9, 32'hDEAD);
        tick(); idle();
        tick();
        chk("ooo_p0_rid3", {iss_valid[0], iss_rid[0]}, {1'b1, 6'd3});
        chk("ooo_src0", iss_data[0][0], 32'hDEAD);
        tick(); tick();

        // Age order: eight entries woken together issue in dispatch order.
        for (int b = 0; b < 4; b++) begin
            set_slot(0, 6'(10 + 2 * b), 2'b00, 6'd20);
            set_slot(1, 6'(11 + 2 * b), 2'b00, 6'd20);
            tick(); idle();
        end
        chk("age_full_count", count, 8);
        chk("age_full_ready", disp_ready, 1'b0);
        set_cdb(0, 6'd20, $urandom);
        tick(); idle();
        for (int b = 0; b < 4; b++) begin
            tick();
            chk("age_pair", {iss_valid, iss_rid[1], iss_rid[0]},
                            {2'b11, 6'(11 + 2 * b), 6'(10 + 2 * b)});
        end
        tick(); tick();

        // Backpressure on port 0.
        iss_ready = 2'b10;
        set_slot(0, 6'd5, 2'b11, 6'd0); set_slot(1, 6'd6, 2'b11, 6'd0);
        tick();
        set_slot(0, 6'd7, 2'b11, 6'd0); set_slot(1, 6'd8, 2'b11, 6'd0);
        tick();
        chk("bp_a2", {iss_valid, iss_rid[1], iss_rid[0]}, {2'b11, 6'd6, 6'd5});
        set_slot(0, 6'd9, 2'b11, 6'd0); set_slot(1, 6'd10, 2'b11, 6'd0);
        tick(); idle();
        chk("bp_a3", {iss_valid, iss_rid[1], iss_rid[0]}, {2'b11, 6'd7, 6'd5});
        tick();
        chk("bp_a4", {iss_valid, iss_rid[1], iss_rid[0]}, {2'b11, 6'd8, 6'd5});
        iss_ready = 2'b11;
        tick();
        chk("bp_release", {iss_valid, iss_rid[1], iss_rid[0]}, {2'b11, 6'd10, 6'd9});
        tick(); tick();

        // Full: count 7 blocks dispatch.
        for (int b = 0; b < 3; b++) begin
            set_slot(0, 6'(30 + 2 * b), 2'b00, 6'd30);
            set_slot(1, 6'(31 + 2 * b), 2'b00, 6'd30);
            tick(); idle();
        end
        set_slot(1, 6'd37, 2'b00, 6'd30);
        tick(); idle();
        chk("full_count7", count, 7);
        chk("full_disp_ready", disp_ready, 1'b0);
        set_slot(0, 6'd40, 2'b11, 6'd0); set_slot(1, 6'd41, 2'b11, 6'd0);
        tick(); idle();
        chk("full_no_change", {count, iss_valid}, {4'd7, 2'b00});
        set_cdb(0, 6'd30, $urandom);
        tick(); idle();
        repeat (6) tick();
        chk("full_drained", count, 0);

        // Bypass, with both CDBs matching: the lower bus supplies the data.
        set_slot(0, 6'd41, 2'b10, 6'd12);
        set_cdb(0, 6'd12, 32'h55);
        set_cdb(1, 6'd12, 32'h66);
        tick(); idle();
        tick();
        chk("bypass_rid", {iss_valid[0], iss_rid[0]}, {1'b1, 6'd41});
        chk("bypass_data", iss_data[0][0], 32'h55);
        tick();

        // Flush with staged ports, dispatch and CDB traffic in the same cycle.
        iss_ready = 2'b00;
        set_slot(0, 6'd51, 2'b11, 6'd0); set_slot(1, 6'd52, 2'b11, 6'd0);
        tick();
        for (int b = 0; b < 3; b++) begin
            set_slot(0, 6'(53 + 2 * b), 2'b00, 6'd50);
            set_slot(1, 6'(54 + 2 * b), 2'b00, 6'd50);
            tick(); idle();
        end
        chk("pre_flush", {count, iss_valid}, {4'd6, 2'b11});
        flush = 1'b1;
        set_slot(0, 6'd60, 2'b11, 6'd0); set_slot(1, 6'd61, 2'b11, 6'd0);
        set_cdb(0, 6'd50, $urandom);
        tick(); idle();
        iss_ready = 2'b11;
        chk("flush_state", {count, iss_valid, disp_ready}, {4'd0, 2'b00, 1'b1});
        for (int b = 0; b < 4; b++) begin
            tick();
            chk("post_flush_idle", iss_valid, 2'b00);
        end

        // Asynchronous reset between clock edges.
        set_slot(0, 6'd1, 2'b00, 6'd2); set_slot(1, 6'd2, 2'b00, 6'd2);
        tick(); idle();
        chk("arst_pre", count, 2);
        #2 rst_n = 1'b0;
        #1 chk("arst_async", {count, iss_valid, disp_ready}, {4'd0, 2'b00, 1'b1});
        tick();
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            disp_valid = 2'($urandom);
            for (int k = 0; k < DC; k++) begin
                disp_rid[k]     = 6'($urandom);
                disp_src_rdy[k] = 2'($urandom);
                for (int s = 0; s < SC; s++) begin
                    disp_src_rid[k][s]  = 6'($urandom_range(0, 7));
                    disp_src_data[k][s] = $urandom;
                end
                disp_payload[k] = {$urandom, $urandom};
            end
            for (int c = 0; c < CC; c++) begin
                cdb_valid[c] = 1'($urandom);
                cdb_rid[c]   = 6'($urandom_range(0, 7));
                cdb_data[c]  = $urandom;
            end
            for (int p = 0; p < IC; p++) iss_ready[p] = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 63) == 0);
            tick();
        end
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wired_iq_age.md
# wired_iq_age

Parametrised, age-ordered issue queue for the Wired out-of-order backend. It sits between dispatch (P stage) and one cluster of function units (ALU, MDU or LSU). It accepts up to DISP_CNT instructions per cycle, wakes up operands by snooping CDB_CNT result buses, and issues up to ISSUE_CNT ready instructions per cycle, oldest first, into registered per-port output slots with valid/ready handshake. A flush discards all queued and staged work.

## Interface
- IQ_SIZE, 8: number of entries; ≥ DISP_CNT.
- DISP_CNT, 2: dispatch slots per cycle.
- ISSUE_CNT, 2: issue ports; ≤ IQ_SIZE.
- CDB_CNT, 2: snooped result buses.
- SRC_CNT, 2: source operands per entry.
- DATA_W, 32: operand width.
- RID_W, 6: ROB id width.
- PAYLOAD_W, 64: opaque static payload (op, pc, ...).
- clk  in  1  clock. Single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous discard of all state.
- disp_valid_i  in  DISP_CNT  per-slot valid.
- disp_rid_i  in  DISP_CNT×RID_W  destination ROB id.
- disp_src_rdy_i  in  DISP_CNT×SRC_CNT  operand already available.
- disp_src_rid_i  in  DISP_CNT×SRC_CNT×RID_W  producer id of each waiting operand.
- disp_src_data_i  in  DISP_CNT×SRC_CNT×DATA_W  operand value, valid when rdy.
- disp_payload_i  in  DISP_CNT×PAYLOAD_W  static payload.
- disp_ready_o  out  1  all slots may be accepted this cycle.
- cdb_valid_i  in  CDB_CNT; cdb_rid_i  in  CDB_CNT×RID_W; cdb_data_i  in  CDB_CNT×DATA_W: result broadcast.
- iss_valid_o  out  ISSUE_CNT  staged instruction valid.
- iss_rid_o  out  ISSUE_CNT×RID_W; iss_data_o  out  ISSUE_CNT×SRC_CNT×DATA_W; iss_payload_o  out  ISSUE_CNT×PAYLOAD_W.
- iss_ready_i  in  ISSUE_CNT  FU/CDB FIFO accepts the staged instruction.
- count_o  out  $clog2(IQ_SIZE+1)  occupied entries.

## Operation
- Reset values: all entries invalid, age matrix 0, iss_valid_o=0, count_o=0, disp_ready_o=1. Data and payload registers are don't-care.
- disp_ready_o = (IQ_SIZE − count_q) ≥ DISP_CNT. It is derived from the registered count only, so entries freed this cycle are not counted. Slot k is accepted iff disp_valid_i[k] & disp_ready_o. Valid bits need not be contiguous.
- Allocation: accepted slots take free entries in ascending slot order, lowest free index first.
- Age matrix age[i][j]=1 means entry i is older than entry j.
  - A new entry is younger than every entry valid at the start of the cycle.
  - Among same-cycle dispatches, a lower slot is older.
  - Rows and columns of freed entries are cleared.
- Wakeup: a waiting operand with cdb_valid_i[c] and a matching rid captures cdb_data_i[c] and is marked ready.
  - A dispatching slot whose operand matches a same-cycle CDB is written ready with CDB data (bypass).
  - If several CDBs match, the lowest c wins.
- Entry ready = valid & all SRC_CNT operands ready (registered state only; no same-cycle wakeup-to-select).
- Port load enable: ld[p] = !iss_valid_o[p] | iss_ready_i[p].
  - Port 0 takes the oldest ready entry. Port p takes the oldest ready entry not taken by a loading port < p.
  - A port with ld[p]=0 takes nothing.
  - The taken entry is freed and its rid, operands and payload are copied into the port register.
  - If ld[p]=1 and no candidate exists, iss_valid_o[p] goes to 0.
- count_q updates as count_q + accepted − issued each cycle.
- flush_i (highest priority): next cycle all entries and port registers are invalid, the age matrix is 0 and count_o=0. Dispatch, CDB and issue in the flush cycle are ignored.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge.

## Timing
- Dispatch at cycle t with all operands ready: the entry is valid at t+1 and iss_valid_o is asserted at t+2.
- CDB wakeup at t: the entry is ready at t+1 and issued at t+2.
- Throughput: ISSUE_CNT issues per cycle when ports are unstalled.
- A stalled port (iss_valid_o=1, iss_ready_i=0) holds all of its outputs stable.
- No combinational path from iss_ready_i to disp_ready_o. The iss_ready_i → iss_valid_o path passes through registers only.

## Test plan
- Reset: hold rst_n low for 3 cycles then release. Require iss_valid_o=0, count_o=0, disp_ready_o=1.
- Out-of-order issue: dispatch rid 3 (src0 waiting on rid 9) in slot 0 and rid 4 (ready) in slot 1. At t+2, port 0 issues rid 4.
  - Drive cdb rid 9 with data 0xDEAD at t+3. Require rid 3 issued at t+5 with src0 = 0xDEAD.
- Age order: fill 8 entries with rids 10..17, all waiting on rid 20, then broadcast rid 20.
  - Require issue pairs (10,11), (12,13), (14,15), (16,17) on ports (0,1) over 4 consecutive cycles.
- Backpressure: hold iss_ready_i[0]=0 with rid 5 staged. Port 0 must hold rid 5 stable while port 1 issues the next-oldest entries.
  - Release iss_ready_i[0]. Port 0 loads the oldest remaining entry on the next cycle.
- Full and bypass:
  - With count 7 and DISP_CNT=2, require disp_ready_o=0 and no state change from dispatch.
  - Dispatch src rid 12 not ready while cdb rid 12 carries 0x55. Require issue 2 cycles later with operand 0x55.
- Flush: assert flush_i while dispatch and CDB traffic are active and count_o=6. Next cycle require count_o=0, iss_valid_o=0 and disp_ready_o=1, with no later issue of pre-flush rids.
